// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer: opcodes, FSM
// encoding, queue entry layout and the response packing helper.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int RSP_W = 5;
    localparam int CMD_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef struct packed {
        logic [RSP_W-1:0] data;
        logic             err;
    } rsp_t;

    // Compare results are only trustworthy when exactly one flag is set.
    function automatic rsp_t pack_rsp(input logic [1:0] op,
                                      input logic [4:0] result,
                                      input logic [3:0] answer,
                                      input logic       eq,
                                      input logic       less,
                                      input logic       great);
        rsp_t r;
        r = '0;
        case (op)
            OP_CMP: begin
                r.data = {2'b00, great, less, eq};
                r.err  = !$onehot({great, less, eq});
            end
            OP_AND:  r.data = {1'b0, answer};
            default: r.data = result;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: power-of-two ring buffer with wrapping pointers and an
// occupancy count; push is dropped when full, pop is dropped when empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequencer in front of a combinational 4-bit ALU: queues commands, drives
// the ALU from registers, waits SETTLE cycles, then returns a packed response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic       alu_a0,
    output logic       alu_a1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_result,
    input  logic [3:0] alu_answer,
    input  logic       alu_eq,
    input  logic       alu_less,
    input  logic       alu_great,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_op,
    output logic [4:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_t              drv_q, drv_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [1:0]        rsp_op_q, rsp_op_d;
    rsp_t              rsp_q, rsp_d;

    cmd_t              fifo_in, fifo_head;
    logic              fifo_full, fifo_empty, pop;
    logic [FCNT_W-1:0] fifo_count;

    assign fifo_in = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   (fifo_in),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drv_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drv_q       <= drv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_q       <= rsp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drv_d       = drv_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_d       = rsp_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    drv_d   = fifo_head;
                    cnt_d   = CNT_W'(SETTLE);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_op_d    = drv_q.op;
                    rsp_d       = pack_rsp(drv_q.op, alu_result, alu_answer,
                                           alu_eq, alu_less, alu_great);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // A waiting command goes straight back to ISSUE, skipping IDLE.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (pop) begin
                        drv_d   = fifo_head;
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop = !fifo_empty &&
              ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        busy      = (state_q != IDLE) || (fifo_count != '0);
        cmd_ready = !fifo_full;
        alu_a1    = drv_q.op[1];
        alu_a0    = drv_q.op[0];
        alu_a     = drv_q.a;
        alu_b     = drv_q.b;
        rsp_valid = rsp_valid_q;
        rsp_op    = rsp_op_q;
        rsp_data  = rsp_q.data;
        rsp_err   = rsp_q.err;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached
// to the drive/sample ports; bad_cmp forces eq and less together.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       alu_a0, alu_a1;
    logic [3:0] alu_a, alu_b;
    logic [4:0] alu_result;
    logic [3:0] alu_answer;
    logic       alu_eq, alu_less, alu_great;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_op;
    logic [4:0] rsp_data;
    logic       rsp_err, busy;
    logic       bad_cmp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a0     (alu_a0),
        .alu_a1     (alu_a1),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_answer (alu_answer),
        .alu_eq     (alu_eq),
        .alu_less   (alu_less),
        .alu_great  (alu_great),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_op     (rsp_op),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always_comb begin
        alu_result = alu_a0 ? ({1'b0, alu_a} - {1'b0, alu_b})
                            : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_answer = alu_a & alu_b;
        alu_eq     = (alu_a == alu_b) || bad_cmp;
        alu_less   = (alu_a <  alu_b) || bad_cmp;
        alu_great  = (alu_a >  alu_b) && !bad_cmp;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_op = op;
        cmd_a  = a;
        cmd_b  = b;
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    // Single command into an idle sequencer, response checked then accepted.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [4:0] exp_d, input logic exp_e);
        set_cmd(op, a, b);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_rsp({tag, "_valid"});
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, "_op"},   32'(rsp_op),   32'(op));
        check({tag, "_err"},  32'(rsp_err),  32'(exp_e));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [1:0] bops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [3:0] bas  [6] = '{4'd1, 4'd9, 4'd6, 4'd15, 4'd15, 4'd9};
    logic [3:0] bbs  [6] = '{4'd2, 4'd4, 4'd6, 4'd5, 4'd15, 4'd2};
    logic [4:0] bexp [6] = '{5'd3, 5'd5, 5'b00001, 5'd5, 5'b11110, 5'b00100};

    initial begin
        int got, last, saw;
        logic drop, c5_acc;

        rst_n     = 1'b0;
        bad_cmp   = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        set_cmd(2'b00, 4'd7, 4'd9);
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);

        // ADD 7+9 accepted at edge N.
        rst_n = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_n_busy",    32'(busy),  32'd1);
        check("lat_n_alu_a",   32'(alu_a), 32'd0);
        tick();
        check("lat_n1_alu_a",  32'(alu_a),     32'd7);
        check("lat_n1_alu_b",  32'(alu_b),     32'd9);
        check("lat_n1_rspv",   32'(rsp_valid), 32'd0);
        tick();
        check("lat_n2_rspv",   32'(rsp_valid), 32'd1);
        check("lat_n2_data",   32'(rsp_data),  32'b10000);
        check("lat_n2_op",     32'(rsp_op),    32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("add_done_rspv", 32'(rsp_valid), 32'd0);
        check("add_done_busy", 32'(busy),      32'd0);

        run_cmd("cmp_less", 2'b10, 4'd3, 4'd12, 5'b00010, 1'b0);
        bad_cmp = 1'b1;
        run_cmd("cmp_bad",  2'b10, 4'd5, 4'd5,  5'b00011, 1'b1);
        run_cmd("and_bad",  2'b11, 4'b1100, 4'b1010, 5'b01000, 1'b0);
        bad_cmp = 1'b0;
        run_cmd("and",      2'b11, 4'b1100, 4'b1010, 5'b01000, 1'b0);
        run_cmd("sub",      2'b01, 4'd5, 4'd2, 5'd3, 1'b0);
        run_cmd("sub_neg",  2'b01, 4'd2, 4'd5, 5'b11101, 1'b0);

        // Back-to-back with the consumer stalled: one command sits in the
        // drive regs, four fill the queue, the sixth is refused.
        for (int i = 0; i < 6; i++) begin
            set_cmd(bops[i], bas[i], bbs[i]);
            cmd_valid = 1'b1;
            check("b2b_ready", 32'(cmd_ready), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) tick();
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            check("hold_rspv",  32'(rsp_valid), 32'd1);
            check("hold_data",  32'(rsp_data),  32'(bexp[0]));
            check("hold_op",    32'(rsp_op),    32'(bops[0]));
            check("hold_alu_a", 32'(alu_a),     32'(bas[0]));
            check("hold_ready", 32'(cmd_ready), 32'd0);
        end

        rsp_ready = 1'b1;
        got = 0;
        last = 0;
        c5_acc = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            drop = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                check("drain_data", 32'(rsp_data), 32'(bexp[got]));
                check("drain_op",   32'(rsp_op),   32'(bops[got]));
                if (got > 0) check("drain_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
            end
            tick();
            if (drop) begin
                cmd_valid = 1'b0;
                c5_acc = 1'b1;
            end
        end
        check("drain_count", 32'(got),    32'd6);
        check("c5_accepted", 32'(c5_acc), 32'd1);
        check("drain_busy",  32'(busy),   32'd0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;

        // Reach ISSUE with two commands still queued, then reset.
        for (int i = 0; i < 4; i++) begin
            set_cmd(2'b00, 4'(i), 4'd1);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("pre_rst_rspv", 32'(rsp_valid), 32'd0);
        check("pre_rst_busy", 32'(busy),      32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rspv",  32'(rsp_valid), 32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_alu_a", 32'(alu_a),     32'd0);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) saw++;
        end
        check("post_rst_stale", 32'(saw),  32'd0);
        check("post_rst_busy",  32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
